mem_clear_seq: RTL and testbench

- Address/write-strobe sequencer that sits directly upstream of the SDRAM and DDR3 controllers in the menu core.
- It sweeps a memory range and writes a constant fill value to every word, so that cores loaded after the menu start with clean RAM.
- It replaces the free-running write counter with a proper handshake, a configurable pacing gap, completion status and progress reporting.
- One instance feeds each memory controller.

---
 rtl/mem_clear_seq.sv | 93 +++++++++
 tb/tb_mem_clear_seq.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mem_clear_seq.sv
// mem_clear_seq: sweeps a word range writing a constant fill value, with handshake, pacing gap and status
module mem_clear_seq #(
   parameter int                 ADDR_W    = 25,
   parameter int                 DATA_W    = 16,
   parameter logic [DATA_W-1:0]  FILL      = '0,
   parameter logic [ADDR_W-1:0]  LAST_ADDR = {ADDR_W{1'b1}},
   parameter int                 GAP       = 9
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic              start,
   input  logic              abort,
   input  logic              mem_busy,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   output logic              mem_we,
   output logic              active,
   output logic              done,
   output logic [7:0]        progress
);
   localparam int GW = GAP > 1 ? $clog2(GAP) : 1;
   localparam logic [GW-1:0] GAP_LD = GW'(GAP > 0 ? GAP - 1 : 0);
   typedef enum logic [1:0] {ST_IDLE, ST_GAP, ST_REQ, ST_FIN} state_t;
   state_t            state, state_nx;
   logic [ADDR_W-1:0] addr_nx;
   logic [GW-1:0]     cnt, cnt_nx;
   logic              done_nx;
   assign mem_din  = FILL;
   assign mem_we   = state == ST_REQ;
   assign active   = state == ST_REQ || state == ST_GAP;
   assign progress = mem_addr[ADDR_W-1 -: 8];
   // state, address, gap counter and sticky done; reset forces idle outputs at once
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state    <= ST_IDLE;
         mem_addr <= '0;
         cnt      <= '0;
         done     <= 1'b0;
      end else begin
         state    <= state_nx;
         mem_addr <= addr_nx;
         cnt      <= cnt_nx;
         done     <= done_nx;
      end
   end
   // next-state: abort beats start, a final accept ends the sweep, GAP=0 keeps strobing every cycle
   always_comb begin
      state_nx = state;
      addr_nx  = mem_addr;
      cnt_nx   = cnt;
      done_nx  = done;
      case (state)
         ST_IDLE, ST_FIN: begin
            if (start && !abort) begin
               state_nx = ST_REQ;
               addr_nx  = '0;
               done_nx  = 1'b0;
            end
         end
         ST_GAP: begin
            if (abort) begin
               state_nx = ST_IDLE;
               addr_nx  = '0;
               cnt_nx   = '0;
               done_nx  = 1'b0;
            end else if (cnt == '0) begin
               state_nx = ST_REQ;
            end else begin
               cnt_nx = cnt - GW'(1);
            end
         end
         default: begin
            if (abort) begin
               state_nx = ST_IDLE;
               addr_nx  = '0;
               cnt_nx   = '0;
               done_nx  = 1'b0;
            end else if (!mem_busy) begin
               if (mem_addr == LAST_ADDR) begin
                  state_nx = ST_FIN;
                  done_nx  = 1'b1;
               end else begin
                  addr_nx = mem_addr + ADDR_W'(1);
                  if (GAP > 0) begin
                     state_nx = ST_GAP;
                     cnt_nx   = GAP_LD;
                  end
               end
            end
         end
      endcase
   end
endmodule

// File: tb/tb_mem_clear_seq.sv
// tb_mem_clear_seq: directed checks of sweep timing, busy hold, abort, start collisions and async reset
module tb_mem_clear_seq;
   logic        clk_sys = 1'b0;
   logic        reset_n = 1'b0;
   int          vectors = 0;
   int          miscompares = 0;
   logic        start_a = 0, abort_a = 0, busy_a = 0;
   logic        start_b = 0, abort_b = 0, busy_b = 0;
   logic        start_c = 0, abort_c = 0, busy_c = 0;
   logic [7:0]  a_addr, c_addr, a_prog, b_prog, c_prog;
   logic [24:0] b_addr;
   logic [15:0] a_din, b_din, c_din;
   logic        a_we, a_act, a_done, b_we, b_act, b_done, c_we, c_act, c_done;

   mem_clear_seq #(.ADDR_W(8), .FILL(16'hA5C3), .LAST_ADDR(8'd3), .GAP(9)) dut_a (
      .clk_sys(clk_sys), .reset_n(reset_n), .start(start_a), .abort(abort_a), .mem_busy(busy_a),
      .mem_addr(a_addr), .mem_din(a_din), .mem_we(a_we), .active(a_act), .done(a_done), .progress(a_prog));
   mem_clear_seq #(.LAST_ADDR(25'd7), .GAP(0)) dut_b (
      .clk_sys(clk_sys), .reset_n(reset_n), .start(start_b), .abort(abort_b), .mem_busy(busy_b),
      .mem_addr(b_addr), .mem_din(b_din), .mem_we(b_we), .active(b_act), .done(b_done), .progress(b_prog));
   mem_clear_seq #(.ADDR_W(8), .FILL(16'h1234), .LAST_ADDR(8'd7), .GAP(2)) dut_c (
      .clk_sys(clk_sys), .reset_n(reset_n), .start(start_c), .abort(abort_c), .mem_busy(busy_c),
      .mem_addr(c_addr), .mem_din(c_din), .mem_we(c_we), .active(c_act), .done(c_done), .progress(c_prog));

   always #5 clk_sys = ~clk_sys;

   task automatic tick;
      @(posedge clk_sys);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int ea;
      logic ew;
      #2;
      chk("rst a_we", a_we, 0);
      chk("rst a_addr", a_addr, 0);
      chk("rst a_act", a_act, 0);
      chk("rst a_done", a_done, 0);
      chk("rst a_din", a_din, 16'hA5C3);
      chk("rst b_din", b_din, 16'h0000);
      chk("rst c_din", c_din, 16'h1234);
      chk("rst b_we", b_we, 0);
      chk("rst c_we", c_we, 0);
      chk("rst b_prog", b_prog, 0);
      tick;
      tick;
      reset_n = 1'b1;
      tick;
      // GAP=9 sweep of 4 words
      start_a = 1;
      tick;
      start_a = 0;
      for (int c = 1; c <= 32; c++) begin
         ea = (c + 8) / 10 > 3 ? 3 : (c + 8) / 10;
         chk($sformatf("t1 we c%0d", c), a_we, c == 1 || c == 11 || c == 21 || c == 31);
         chk($sformatf("t1 addr c%0d", c), a_addr, ea);
         chk($sformatf("t1 prog c%0d", c), a_prog, ea);
         chk($sformatf("t1 act c%0d", c), a_act, c <= 31);
         chk($sformatf("t1 done c%0d", c), a_done, c >= 32);
         if (c < 32) tick;
      end
      chk("t1 din", a_din, 16'hA5C3);
      // GAP=0 back-to-back writes
      start_b = 1;
      tick;
      start_b = 0;
      for (int c = 1; c <= 9; c++) begin
         chk($sformatf("t2 we c%0d", c), b_we, c <= 8);
         chk($sformatf("t2 addr c%0d", c), b_addr, c <= 8 ? c - 1 : 7);
         chk($sformatf("t2 act c%0d", c), b_act, c <= 8);
         chk($sformatf("t2 done c%0d", c), b_done, c == 9);
         if (c < 9) tick;
      end
      abort_b = 1;
      tick;
      abort_b = 0;
      chk("t2 fin abort done", b_done, 1);
      chk("t2 fin abort addr", b_addr, 7);
      chk("t2 fin abort act", b_act, 0);
      start_b = 1;
      abort_b = 1;
      tick;
      start_b = 0;
      abort_b = 0;
      chk("t2 fin start+abort we", b_we, 0);
      chk("t2 fin start+abort done", b_done, 1);
      // busy hold at address 2, plus a start pulse while active
      start_a = 1;
      tick;
      start_a = 0;
      for (int c = 1; c <= 37; c++) begin
         busy_a = c >= 21 && c <= 25;
         start_a = c == 15;
         ew = c == 1 || c == 11 || (c >= 21 && c <= 26) || c == 36;
         ea = c == 1 ? 0 : c <= 11 ? 1 : c <= 26 ? 2 : 3;
         chk($sformatf("t3 we c%0d", c), a_we, ew);
         chk($sformatf("t3 addr c%0d", c), a_addr, ea);
         chk($sformatf("t3 done c%0d", c), a_done, c >= 37);
         if (c < 37) tick;
      end
      busy_a = 0;
      start_a = 0;
      // abort during the gap after address 4
      start_c = 1;
      tick;
      start_c = 0;
      for (int c = 1; c <= 14; c++) begin
         chk($sformatf("t4 we c%0d", c), c_we, c % 3 == 1);
         chk($sformatf("t4 addr c%0d", c), c_addr, (c + 1) / 3);
         if (c < 14) tick;
      end
      chk("t4 act before abort", c_act, 1);
      abort_c = 1;
      tick;
      abort_c = 0;
      chk("t4 abort we", c_we, 0);
      chk("t4 abort addr", c_addr, 0);
      chk("t4 abort act", c_act, 0);
      chk("t4 abort done", c_done, 0);
      start_c = 1;
      tick;
      start_c = 0;
      chk("t4 restart we", c_we, 1);
      chk("t4 restart addr", c_addr, 0);
      chk("t4 restart act", c_act, 1);
      tick;
      chk("t4 gap addr", c_addr, 1);
      chk("t4 gap we", c_we, 0);
      start_c = 1;
      abort_c = 1;
      tick;
      start_c = 0;
      abort_c = 0;
      chk("t5 start+abort act", c_act, 0);
      chk("t5 start+abort addr", c_addr, 0);
      chk("t5 start+abort we", c_we, 0);
      start_c = 1;
      abort_c = 1;
      tick;
      start_c = 0;
      abort_c = 0;
      chk("t5 idle start+abort act", c_act, 0);
      tick;
      chk("t5 idle start+abort we", c_we, 0);
      // asynchronous reset between edges while strobing
      start_a = 1;
      tick;
      start_a = 0;
      chk("t6 pre we", a_we, 1);
      chk("t6 pre done", a_done, 0);
      #3;
      reset_n = 1'b0;
      #1;
      chk("t6 async we", a_we, 0);
      chk("t6 async addr", a_addr, 0);
      chk("t6 async act", a_act, 0);
      chk("t6 async b_done", b_done, 0);
      chk("t6 async b_addr", b_addr, 0);
      chk("t6 async din", a_din, 16'hA5C3);
      @(posedge clk_sys);
      #1;
      reset_n = 1'b1;
      chk("t6 released we", a_we, 0);
      start_a = 1;
      tick;
      start_a = 0;
      chk("t6 resume we", a_we, 1);
      chk("t6 resume addr", a_addr, 0);
      chk("t6 resume act", a_act, 1);
      tick;
      chk("t6 resume addr1", a_addr, 1);
      chk("t6 resume gap we", a_we, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
